// File: rtl/switch_code_entry.sv
// Slide-switch code entry: synchronise and debounce the switches, turn each press
// into a digit and shift it into a DIGITS-deep code register with clear/delete.
module switch_code_entry #(
  parameter int NUM_SW    = 10,
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int DEBOUNCE  = 4,
  parameter int ACTIVE_UP = 1
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic [NUM_SW-1:0]            SW,
  input  logic                         CLEAR,
  input  logic                         DEL,
  output logic [NUM_SW-1:0]            SW_State,
  output logic [DIGIT_W-1:0]           Digit,
  output logic                         Digit_Valid,
  output logic [DIGITS*DIGIT_W-1:0]    Code,
  output logic [$clog2(DIGITS+1)-1:0]  Code_Cnt,
  output logic                         Code_Full,
  output logic                         Multi_Err,
  output logic                         Ovf_Err
);

  localparam int CNT_W  = $clog2(DIGITS+1);
  localparam int CODE_W = DIGITS*DIGIT_W;
  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [NUM_SW-1:0] INACT = (ACTIVE_UP != 0) ? '0 : '1;

  typedef enum logic {ENTRY, FULL} state_t;

  state_t                state, state_nxt;
  logic [NUM_SW-1:0]     sync1, sync2;
  logic [DB_W-1:0]       db_cnt [NUM_SW];
  logic [NUM_SW-1:0]     flip, press;
  logic                  any_press, multi_press;
  logic [DIGIT_W-1:0]    press_idx;
  logic [CODE_W-1:0]     code_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [DIGIT_W-1:0]    digit_nxt;
  logic                  dv_nxt, multi_nxt, ovf_nxt;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync1 <= INACT;
      sync2 <= INACT;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

  // flip marks the edge on which the debounce count would reach DEBOUNCE
  always_comb begin
    for (int unsigned i = 0; i < NUM_SW; i++)
      flip[i] = (sync2[i] != SW_State[i]) && (db_cnt[i] == DB_W'(DEBOUNCE-1));
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      SW_State <= INACT;
      for (int unsigned i = 0; i < NUM_SW; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        if (sync2[i] == SW_State[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          SW_State[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A flip is a press when the new level is the active one
  always_comb begin
    press       = flip & ((ACTIVE_UP != 0) ? sync2 : ~sync2);
    any_press   = |press;
    multi_press = |(press & (press - NUM_SW'(1)));
    press_idx   = '0;
    for (int unsigned i = 0; i < NUM_SW; i++)
      if (press[i]) press_idx = DIGIT_W'(i);
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = Code;
    cnt_nxt   = Code_Cnt;
    digit_nxt = Digit;
    dv_nxt    = 1'b0;
    multi_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    if (CLEAR) begin
      code_nxt  = '0;
      cnt_nxt   = '0;
      state_nxt = ENTRY;
    end else if (DEL) begin
      if (Code_Cnt != '0) begin
        code_nxt  = Code >> DIGIT_W;
        cnt_nxt   = Code_Cnt - 1'b1;
        state_nxt = ENTRY;
      end
    end else if (multi_press) begin
      multi_nxt = 1'b1;
    end else if (any_press) begin
      case (state)
        ENTRY: begin
          code_nxt  = (Code << DIGIT_W) | CODE_W'(press_idx);
          cnt_nxt   = Code_Cnt + 1'b1;
          digit_nxt = press_idx;
          dv_nxt    = 1'b1;
          if (Code_Cnt == CNT_W'(DIGITS-1)) state_nxt = FULL;
        end
        FULL:    ovf_nxt = 1'b1;
        default: state_nxt = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state       <= ENTRY;
      Code        <= '0;
      Code_Cnt    <= '0;
      Digit       <= '0;
      Digit_Valid <= 1'b0;
      Multi_Err   <= 1'b0;
      Ovf_Err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      Code        <= code_nxt;
      Code_Cnt    <= cnt_nxt;
      Digit       <= digit_nxt;
      Digit_Valid <= dv_nxt;
      Multi_Err   <= multi_nxt;
      Ovf_Err     <= ovf_nxt;
    end
  end

  assign Code_Full = (state == FULL);

endmodule

// File: tb/tb_switch_code_entry.sv
// Scoreboard bench for switch_code_entry: a digit-queue reference model predicts
// each output pulse; a negedge monitor pops and compares whenever the DUT pulses.
module tb_switch_code_entry;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        RESET;
  logic [9:0]  sw, sw_n;
  logic        clear, del;
  logic        clear_n, del_n;
  logic [9:0]  sw_state, sw_state_n;
  logic [3:0]  digit, digit_n;
  logic        digit_valid, digit_valid_n;
  logic [15:0] code, code_n;
  logic [2:0]  code_cnt, code_cnt_n;
  logic        code_full, code_full_n;
  logic        multi_err, multi_err_n;
  logic        ovf_err, ovf_err_n;

  always #5 clk = ~clk;

  switch_code_entry #(.NUM_SW(10), .DIGITS(4), .DIGIT_W(4), .DEBOUNCE(DB), .ACTIVE_UP(1)) u_dut (
    .clk(clk), .RESET(RESET), .SW(sw), .CLEAR(clear), .DEL(del),
    .SW_State(sw_state), .Digit(digit), .Digit_Valid(digit_valid), .Code(code),
    .Code_Cnt(code_cnt), .Code_Full(code_full), .Multi_Err(multi_err), .Ovf_Err(ovf_err));

  switch_code_entry #(.NUM_SW(10), .DIGITS(4), .DIGIT_W(4), .DEBOUNCE(DB), .ACTIVE_UP(0)) u_dut_n (
    .clk(clk), .RESET(RESET), .SW(sw_n), .CLEAR(clear_n), .DEL(del_n),
    .SW_State(sw_state_n), .Digit(digit_n), .Digit_Valid(digit_valid_n), .Code(code_n),
    .Code_Cnt(code_cnt_n), .Code_Full(code_full_n), .Multi_Err(multi_err_n), .Ovf_Err(ovf_err_n));

  typedef struct {
    int          kind;   // 0 digit accepted, 1 multi press, 2 overflow
    int          cyc;
    logic [15:0] code;
    int          cnt;
    int          dig;
  } ev_t;

  ev_t        exp_q[$];
  int         q[$];        // held digits, oldest first
  logic [9:0] mdl_sw;
  int         last_digit;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         dv_seen = 0;
  int         dv_n_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mcode();
    logic [15:0] c = '0;
    foreach (q[i]) c = (c << 4) | 16'(q[i]);
    return c;
  endfunction

  task automatic model_step(input logic [9:0] pr, input bit clr, input bit dl, input int at);
    ev_t e;
    int  n = $countones(pr);
    int  idx = 0;
    for (int i = 0; i < 10; i++) if (pr[i]) idx = i;
    e.kind = -1;
    if (clr) q.delete();
    else if (dl) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (n > 1) e.kind = 1;
    else if (n == 1) begin
      if (q.size() == 4) e.kind = 2;
      else begin
        q.push_back(idx);
        last_digit = idx;
        e.kind = 0;
      end
    end
    if (e.kind >= 0) begin
      e.cyc  = at;
      e.code = mcode();
      e.cnt  = q.size();
      e.dig  = last_digit;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".sw_state"}, 32'(sw_state), 32'(mdl_sw));
    check({tag, ".code"}, 32'(code), 32'(mcode()));
    check({tag, ".code_cnt"}, 32'(code_cnt), 32'(q.size()));
    check({tag, ".code_full"}, 32'(code_full), 32'(q.size() == 4));
    check({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Change the switch vector and hold it; optionally drive CLEAR/DEL on the flip edge.
  task automatic change_sw(input logic [9:0] nv, input bit clr, input bit dl);
    @(posedge clk); #1;
    sw = nv;
    model_step(nv & ~mdl_sw, clr, dl, cyc + DB + 2);
    mdl_sw = nv;
    if (clr || dl) begin
      repeat (DB + 1) @(posedge clk);
      #1 clear = clr; del = dl;
      @(posedge clk);
      #1 clear = 1'b0; del = 1'b0;
      repeat (2) @(posedge clk);
    end else begin
      repeat (DB + 4) @(posedge clk);
    end
    #1 check_state("settle");
  endtask

  task automatic pulse_ctl(input bit clr, input bit dl);
    @(posedge clk); #1 clear = clr; del = dl;
    @(posedge clk); #1 clear = 1'b0; del = 1'b0;
    model_step('0, clr, dl, 0);
    check_state(clr ? "clear" : "del");
  endtask

  task automatic press_release(input int idx);
    change_sw(mdl_sw | (10'b1 << idx), 1'b0, 1'b0);
    change_sw(mdl_sw & ~(10'b1 << idx), 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (!RESET && (digit_valid || multi_err || ovf_err)) begin
      kind = digit_valid ? 0 : (multi_err ? 1 : 2);
      check("pulse_exclusive", 32'(digit_valid + multi_err + ovf_err), 32'd1);
      if (digit_valid) dv_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got kind %0d expected none (t=%0t)", kind, $time);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", 32'(kind), 32'(e.kind));
        check("ev_cycle", 32'(cyc), 32'(e.cyc));
        check("ev_code", 32'(code), 32'(e.code));
        check("ev_cnt", 32'(code_cnt), 32'(e.cnt));
        check("ev_full", 32'(code_full), 32'(e.cnt == 4));
        check("ev_digit", 32'(digit), 32'(e.dig));
      end
    end
    if (!RESET && digit_valid_n) dv_n_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] nv;
    bit         c, d;
    int         r;
    RESET = 1'b1; sw = '0; sw_n = '1;
    clear = 1'b0; del = 1'b0; clear_n = 1'b0; del_n = 1'b0;
    mdl_sw = '0; last_digit = 0;
    repeat (3) @(posedge clk);
    #1 RESET = 1'b0;

    // reset state and quiet switches
    repeat (20) @(posedge clk);
    #1 check_state("reset");
    check("reset.digit", 32'(digit), 32'd0);
    check("reset.no_dv", 32'(dv_seen), 32'd0);
    check("reset_n.sw_state", 32'(sw_state_n), 32'h3ff);
    check("reset_n.code", 32'(code_n), 32'd0);

    // single press on SW[3], release gives nothing
    press_release(3);
    check("sw3.code", 32'(code), 32'h0003);

    // 1,2,5,9 fill the code, fifth press overflows
    pulse_ctl(1'b1, 1'b0);
    press_release(1);
    press_release(2);
    press_release(5);
    press_release(9);
    check("fill.code", 32'(code), 32'h1259);
    press_release(0);
    check("ovf.code", 32'(code), 32'h1259);

    // delete, then clear coincident with a press edge
    pulse_ctl(1'b0, 1'b1);
    check("del.code", 32'(code), 32'h0125);
    r = dv_seen;
    change_sw(mdl_sw | 10'b1, 1'b1, 1'b0);
    check("clear_press.no_dv", 32'(dv_seen), 32'(r));
    change_sw(mdl_sw & ~10'b1, 1'b0, 1'b0);

    // short glitches on SW[2] are ignored
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 sw[2] = 1'b1;
      @(posedge clk); #1 sw[2] = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (DB + 4) @(posedge clk);
    #1 check_state("glitch");

    // simultaneous presses
    change_sw(mdl_sw | 10'h090, 1'b0, 1'b0);
    change_sw(mdl_sw & ~10'h090, 1'b0, 1'b0);

    // asynchronous reset with two digits held
    press_release(7);
    press_release(8);
    check("pre_rst.cnt", 32'(code_cnt), 32'd2);
    @(posedge clk); #3 RESET = 1'b1;
    #1;
    check("async_rst.code", 32'(code), 32'd0);
    check("async_rst.cnt", 32'(code_cnt), 32'd0);
    check("async_rst.digit", 32'(digit), 32'd0);
    q.delete(); exp_q.delete(); mdl_sw = '0; last_digit = 0;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_state("post_rst");

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 99);
      if (r < 10) pulse_ctl(1'b0, 1'b1);
      else if (r < 14) pulse_ctl(1'b1, 1'b0);
      else begin
        nv = mdl_sw ^ (10'b1 << $urandom_range(0, 9));
        if ($urandom_range(0, 5) == 0) nv = nv ^ (10'b1 << $urandom_range(0, 9));
        c = ($urandom_range(0, 19) == 0);
        d = !c && ($urandom_range(0, 14) == 0);
        change_sw(nv, c, d);
      end
    end

    // active-low instance: falling SW[6] is the press, rising is not
    @(posedge clk); #1 sw_n[6] = 1'b0;
    repeat (DB + 4) @(posedge clk);
    #1;
    check("low.digit", 32'(digit_n), 32'd6);
    check("low.code", 32'(code_n), 32'h0006);
    check("low.cnt", 32'(code_cnt_n), 32'd1);
    check("low.dv_count", 32'(dv_n_seen), 32'd1);
    check("low.sw_state", 32'(sw_state_n), 32'h3bf);
    @(posedge clk); #1 sw_n[6] = 1'b1;
    repeat (DB + 4) @(posedge clk);
    #1;
    check("low_release.dv_count", 32'(dv_n_seen), 32'd1);
    check("low_release.sw_state", 32'(sw_state_n), 32'h3ff);

    check("final.pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
